conv_layer_seq: RTL
===================

CONV_LAYER_SEQ -- requirements
Module: conv_layer_seq

Interface
REQ-001 SHALL have parameter IN_CH, default 4, number of input channels.
REQ-002 SHALL have parameter OUT_CH, default 8, number of filters/output channels.
REQ-003 SHALL have parameter K, default 5, kernel taps per channel.
REQ-004 SHALL have parameter DW, default 8, signed sample/weight/result width.
REQ-005 SHALL have parameter SHIFT, default 6, arithmetic right-shift applied to each accumulated sum.
REQ-006 SHALL have ports: clk  in  1  clock; all logic on rising edge.
REQ-007 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-008 SHALL have port en  in  1  global enable; when low, all state and outputs hold.
REQ-009 SHALL have port in_valid  in  1 and in_ready  out  1: window handshake.
REQ-010 SHALL have port in_data  in  IN_CH*K*DW  signed window; tap k of channel c at [(c*K+k)*DW +: DW].
REQ-011 SHALL have ports w_we  in  1, w_addr  in  clog2(OUT_CH*IN_CH*K), w_data  in  DW: weight write port; address = (oc*IN_CH+ic)*K+k.
REQ-012 SHALL have port out_valid  out  1 and out_ready  in  1: result handshake.
REQ-013 SHALL have port out_data  out  OUT_CH*DW  signed results; channel oc at [oc*DW +: DW].
REQ-014 SHALL have port busy  out  1: high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> ACCUM -> SAT -> HOLD -> IDLE; every transition and register update gated by en=1.
REQ-016 SHALL drive in_ready=1 only in IDLE; on in_valid&in_ready&en SHALL register in_data and go to ACCUM.
REQ-017 SHALL in ACCUM process one (oc,ic) pair per cycle: K-tap signed dot product added into accumulator oc, ic inner loop, oc outer, OUT_CH*IN_CH cycles total.
REQ-018 SHALL size accumulators at 2*DW+clog2(IN_CH*K) bits so no intermediate overflow occurs.
REQ-019 SHALL in SAT (one cycle) compute acc>>>SHIFT (floor) and saturate symmetrically: >127 -> 127, <-127 -> -127 (-128 maps to -127); general form +/-(2^(DW-1)-1).
REQ-020 SHALL assert out_valid in HOLD, first cycle exactly OUT_CH*IN_CH+1 enabled cycles after input acceptance (33 for defaults).
REQ-021 SHALL hold out_data stable while out_valid=1 and out_ready=0; on out_valid&out_ready&en return to IDLE next cycle.
REQ-022 SHALL clear all accumulators on input acceptance; no state carries between windows.
REQ-023 SHALL accept weight writes only in IDLE; w_we in any other state SHALL be ignored; writes to w_addr >= OUT_CH*IN_CH*K ignored.
REQ-024 SHALL give weight write priority order: a write and an input acceptance in the same IDLE cycle both take effect; the new weight is used by that window.
REQ-025 SHALL, with en=0 mid-ACCUM, freeze counters and accumulators and resume unchanged when en returns high.

Reset
REQ-026 SHALL on rst=0 asynchronously force IDLE, counters 0, accumulators 0, weights 0, out_data 0, out_valid 0, in_ready 0 while asserted and 1 the first cycle after release.
REQ-027 SHALL on reset mid-ACCUM or HOLD discard the window; no out_valid is produced for it.

Configuration
REQ-028 SHALL support macro CONV_RELU_EN: defined -> negative saturated results replaced by 0 before out_data registration; undefined -> saturated signed results passed unchanged.

Structure
REQ-029 SHALL place the FSM state enum, saturation-limit and accumulator-width functions in shared package conv_pkg.
REQ-030 SHALL use one combinational sub-module kernel_dot (K-tap signed dot product, parameters K and DW).

Verification
REQ-031 Defaults; filter 0 weights all 64, in_data all 1 -> out_data ch0 = 20 (1280>>>6), ch1..7 = 0, out_valid at cycle 33.
REQ-032 All weights 127, all inputs 127 -> every channel 127; all weights -128, inputs 127 -> every channel -127 (0 with CONV_RELU_EN).
REQ-033 Single nonzero product -1 (input -1, weight 1) -> result -1 (floor shift), 0 with CONV_RELU_EN.
REQ-034 out_ready low 10 cycles after out_valid -> out_valid and out_data stable, in_ready 0, w_we writes ignored; ready high -> IDLE next cycle.
REQ-035 en low 5 cycles at ACCUM cycle 10 -> out_valid delayed exactly 5 cycles, identical result.
REQ-036 rst low at ACCUM cycle 12 -> outputs 0 immediately, weights 0, no out_valid; next window completes normally after reloading weights.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the sequential convolution layer.
package conv_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SAT, S_HOLD} conv_state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_width(input int dw, input int in_ch, input int k);
    return 2 * dw + $clog2(in_ch * k);
  endfunction

  function automatic int sat_lim(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction
endpackage

// File: rtl/kernel_dot.sv
// Combinational K-tap signed dot product of one input channel against one filter row.
module kernel_dot #(
  parameter int K  = 5,
  parameter int DW = 8
) (
  input  logic [K*DW-1:0]                x_i,
  input  logic [K*DW-1:0]                w_i,
  output logic signed [2*DW+$clog2(K)-1:0] dot_o
);
  localparam int OW = 2 * DW + $clog2(K);

  logic signed [OW-1:0] xe, we;

  // Operands are widened before multiplying so the product keeps full precision.
  always_comb begin
    dot_o = '0;
    xe    = '0;
    we    = '0;
    for (int k = 0; k < K; k++) begin
      xe    = OW'($signed(x_i[k*DW +: DW]));
      we    = OW'($signed(w_i[k*DW +: DW]));
      dot_o = dot_o + xe * we;
    end
  end
endmodule

// File: rtl/conv_layer_seq.sv
// Sequential conv layer: one (filter, channel) pair per cycle, then shift/saturate.
// Define CONV_RELU_EN to clamp negative saturated results to zero.
module conv_layer_seq import conv_pkg::*; #(
  parameter int IN_CH  = 4,
  parameter int OUT_CH = 8,
  parameter int K      = 5,
  parameter int DW     = 8,
  parameter int SHIFT  = 6
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [IN_CH*K*DW-1:0]              in_data,
  input  logic                               w_we,
  input  logic [cw(OUT_CH*IN_CH*K)-1:0]      w_addr,
  input  logic [DW-1:0]                      w_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [OUT_CH*DW-1:0]               out_data,
  output logic                               busy
);
  localparam int NW  = OUT_CH * IN_CH * K;
  localparam int WA  = cw(NW);
  localparam int OCW = cw(OUT_CH);
  localparam int ICW = cw(IN_CH);
  localparam int AW  = acc_width(DW, IN_CH, K);
  localparam int PW  = 2 * DW + $clog2(K);
  localparam logic [WA:0]          NW_C = (WA+1)'(NW);
  localparam logic signed [AW-1:0] LIM  = AW'(sat_lim(DW));
  localparam logic signed [AW-1:0] NLIM = -LIM;

  conv_state_e             state_q, state_d;
  logic [OCW-1:0]          oc_q;
  logic [ICW-1:0]          ic_q;
  logic [K*DW-1:0]         win_q [IN_CH];
  logic [DW-1:0]           w_q   [NW];
  logic signed [AW-1:0]    acc_q [OUT_CH];
  logic [OUT_CH*DW-1:0]    out_q;

  logic                    accept, last_ic, last_pair;
  logic [K*DW-1:0]         xvec, wvec;
  logic [WA-1:0]           widx;
  logic signed [PW-1:0]    dot;
  logic signed [AW-1:0]    sh;
  logic [OUT_CH*DW-1:0]    sat_vec;

  assign in_ready  = rst & (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = out_q;
  assign accept    = en & in_valid & (state_q == S_IDLE);
  assign last_ic   = (ic_q == ICW'(IN_CH - 1));
  assign last_pair = last_ic & (oc_q == OCW'(OUT_CH - 1));

  always_comb begin
    state_d = state_q;
    if (en) begin
      case (state_q)
        S_IDLE:  if (in_valid)  state_d = S_ACCUM;
        S_ACCUM: if (last_pair) state_d = S_SAT;
        S_SAT:                  state_d = S_HOLD;
        S_HOLD:  if (out_ready) state_d = S_IDLE;
        default:                state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wvec = '0;
    widx = '0;
    xvec = win_q[ic_q];
    for (int k = 0; k < K; k++) begin
      widx = WA'((int'(oc_q) * IN_CH + int'(ic_q)) * K + k);
      wvec[k*DW +: DW] = w_q[widx];
    end
  end

  kernel_dot #(.K(K), .DW(DW)) u_dot (
    .x_i   (xvec),
    .w_i   (wvec),
    .dot_o (dot)
  );

  // Floor shift, then symmetric clamp so the most negative code never appears.
  always_comb begin
    sat_vec = '0;
    sh      = '0;
    for (int oc = 0; oc < OUT_CH; oc++) begin
      sh = acc_q[oc] >>> SHIFT;
      if (sh > LIM)       sh = LIM;
      else if (sh < NLIM) sh = NLIM;
`ifdef CONV_RELU_EN
      if (sh[AW-1]) sh = '0;
`endif
      sat_vec[oc*DW +: DW] = sh[DW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else if (en && state_q == S_IDLE && w_we && ({1'b0, w_addr} < NW_C)) begin
      w_q[w_addr] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      oc_q    <= '0;
      ic_q    <= '0;
      out_q   <= '0;
      for (int c = 0; c < IN_CH; c++)  win_q[c] <= '0;
      for (int o = 0; o < OUT_CH; o++) acc_q[o] <= '0;
    end else if (en) begin
      state_q <= state_d;
      if (accept) begin
        oc_q <= '0;
        ic_q <= '0;
        for (int c = 0; c < IN_CH; c++)  win_q[c] <= in_data[c*K*DW +: K*DW];
        for (int o = 0; o < OUT_CH; o++) acc_q[o] <= '0;
      end
      if (state_q == S_ACCUM) begin
        acc_q[oc_q] <= acc_q[oc_q] + AW'(dot);
        if (last_ic) begin
          ic_q <= '0;
          oc_q <= last_pair ? '0 : oc_q + 1'b1;
        end else begin
          ic_q <= ic_q + 1'b1;
        end
      end
      if (state_q == S_SAT) out_q <= sat_vec;
    end
  end
endmodule
